// File: rtl/regfile_multi.sv
// Multi-read-port register file with a hardware clear sequence after reset and registered reads.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_multi #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RD_PORTS*ADDR_W-1:0]   read_reg,
  output logic [RD_PORTS*DATA_W-1:0]   read_data,
  input  logic [ADDR_W-1:0]            write_reg,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         reg_write,
  input  logic                         hold,
  output logic                         ready
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           cnt_q, cnt_d;
  logic                        ready_q, ready_d;
  logic [RD_PORTS*DATA_W-1:0]  rdata_q, rdata_d;
  logic [DATA_W-1:0]           regs_q [NUM_REGS];
  logic [DATA_W-1:0]           regs_d [NUM_REGS];

  logic                        wr_en_c;
  logic [ADDR_W-1:0]           rd_addr;
  logic [DATA_W-1:0]           rd_val;

  // Architectural write: only in RUN, and register 0 is hard-wired to zero.
  always_comb begin
    wr_en_c = (state_q == ST_RUN) && reg_write && (write_reg != '0);
  end

  // Clear sequencer and write path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    regs_d  = regs_q;
    case (state_q)
      ST_CLEAR: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_REG) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (wr_en_c) begin
          regs_d[write_reg] = write_data;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Read ports: zero while clearing, frozen under hold (hold wins over forwarding).
  always_comb begin
    rdata_d = rdata_q;
    rd_addr = '0;
    rd_val  = '0;
    if (state_q != ST_RUN) begin
      rdata_d = '0;
    end else if (!hold) begin
      for (int p = 0; p < int'(RD_PORTS); p++) begin
        rd_addr = read_reg[p*ADDR_W +: ADDR_W];
        rd_val  = (rd_addr == '0) ? '0 : regs_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en_c && (rd_addr == write_reg)) begin
          rd_val = write_data;
        end
`endif
        rdata_d[p*DATA_W +: DATA_W] = rd_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; the clear sequence zeroes it once reset is released.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      regs_q <= regs_d;
    end
  end

  assign read_data = rdata_q;
  assign ready     = ready_q;

endmodule

// File: doc/regfile_multi.md
REGFILE_MULTI -- requirements
Module: regfile_multi

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 16, register data width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 4, register address width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL expose parameter RD_PORTS, default 2, number of read ports (legal range 1..4).
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-006 The block SHALL have port read_reg, input, RD_PORTS*ADDR_W, packed read addresses, port p at bits [p*ADDR_W +: ADDR_W].
REQ-007 The block SHALL have port read_data, output, RD_PORTS*DATA_W, packed registered read data, same packing.
REQ-008 The block SHALL have port write_reg, input, ADDR_W, write address.
REQ-009 The block SHALL have port write_data, input, DATA_W, write data.
REQ-010 The block SHALL have port reg_write, input, 1, write enable.
REQ-011 The block SHALL have port hold, input, 1, freezes all read_data registers when high.
REQ-012 The block SHALL have port ready, output, 1, high when the clear sequence is complete and the file accepts writes.

Function
REQ-013 Two-state FSM: CLEAR and RUN; rst_n low forces CLEAR with clear counter = 0.
REQ-014 In CLEAR, each edge with rst_n high SHALL write 0 to register[counter] and increment counter.
REQ-015 The edge that clears register NUM_REGS-1 SHALL move the FSM to RUN and set ready = 1; ready rises exactly NUM_REGS edges after rst_n is sampled high.
REQ-016 In CLEAR, reg_write SHALL be ignored and read_data SHALL be driven 0.
REQ-017 In RUN, reg_write = 1 with write_reg != 0 SHALL store write_data at the edge; writes to register 0 SHALL be discarded.
REQ-018 Register 0 SHALL always read 0.
REQ-019 Read latency SHALL be one cycle: read_data port p after edge N = register[read_reg p sampled at edge N].
REQ-020 hold = 1 in RUN SHALL keep every read_data port unchanged; writes still proceed during hold.
REQ-021 Ports reading the same address SHALL return identical data.
REQ-022 Counter width SHALL be ADDR_W bits; wrap from NUM_REGS-1 is never used because the FSM leaves CLEAR.

Reset
REQ-023 At an edge with rst_n = 0: state = CLEAR, counter = 0, ready = 0, all read_data = 0.
REQ-024 rst_n asserted during CLEAR SHALL restart the sequence from register 0.
REQ-025 rst_n asserted during RUN SHALL drop ready at that edge and re-clear all registers.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, a RUN-state read of an address equal to write_reg, with reg_write = 1 and write_reg != 0 in the same cycle, SHALL return write_data.
REQ-027 Without REGFILE_BYPASS_EN, that read SHALL return the pre-write value; the new value is visible one cycle later.
REQ-028 hold SHALL take priority over bypass in both builds.

Verification
REQ-029 Reset: rst_n low 2 cycles, then high -> ready = 0 for 16 edges, ready = 1 after edge 16, all 16 registers read 0x0000.
REQ-030 Write/read: write 0xBEEF to r5, next cycle read_reg port0 = 5 -> read_data port0 = 0xBEEF one edge later.
REQ-031 Zero register: write 0x1234 to r0, read r0 -> 0x0000.
REQ-032 Bypass: same cycle write 0xA5A5 to r3 and read r3 (old 0x0000) -> 0xA5A5 with REGFILE_BYPASS_EN, 0x0000 without.
REQ-033 Hold: read r5 = 0xBEEF, assert hold, write 0x0001 to r5 and switch read_reg to r7 -> read_data stays 0xBEEF until hold drops, then r7 value.
REQ-034 Mid-clear reset: assert rst_n low at clear edge 7, write during CLEAR -> sequence restarts, ready after 16 further edges, written value absent.
